alu_result_checker: RTL and testbench
=====================================

Name: alu_result_checker

Overview:
- Receiving end of the ALU operand/result interface. Accepts one transaction per handshake: operands A, B, C, opcode, plus result and flags from a reference ALU and from a DUT ALU (structural vs synthesized netlist).
- Compares the two results and checks the reference flags for self-consistency.
- Counts samples and mismatches, and queues mismatch records in a small FIFO for a downstream logger.
- Sits in the ALU equivalence bench in place of manual waveform comparison, and reusable as an on-chip lockstep checker.

Parameters:
- WIDTH, 16, operand/result width
- OPW, 3, opcode width
- DEPTH, 4, mismatch FIFO entries (power of 2, >=2)
- CNT_W, 16, width of each counter
- STOP_ON_ERR, 0, 1 = halt intake after first recorded mismatch

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- clear  in  1  synchronous soft clear (counters, FIFO, pipeline, FSM)
- in_valid  in  1  transaction present
- in_ready  out  1  checker accepts transaction
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B
- c  in  1  carry-in
- opcode  in  OPW  ALU opcode
- w_ref  in  WIDTH  reference result
- zero_ref  in  1  reference zero flag
- neg_ref  in  1  reference negative flag
- w_dut  in  WIDTH  DUT result
- zero_dut  in  1  DUT zero flag
- neg_dut  in  1  DUT negative flag
- err_valid  out  1  FIFO head valid
- err_ready  in  1  consumer pops head
- err_a  out  WIDTH  head operand A
- err_b  out  WIDTH  head operand B
- err_c  out  1  head carry
- err_opcode  out  OPW  head opcode
- err_w_ref  out  WIDTH  head reference result
- err_w_dut  out  WIDTH  head DUT result
- err_code  out  4  head error bits
- sample_cnt  out  CNT_W  accepted transactions
- mismatch_cnt  out  CNT_W  transactions with err_code != 0
- drop_cnt  out  CNT_W  mismatches lost to full FIFO
- halted  out  1  FSM in HALT

Behaviour:
- Reset (rst_n=0 at edge): all outputs 0 except in_ready=1. FIFO empty, stage-1 valid cleared, FSM=RUN. Reset and clear have identical effect; rst_n has priority.
- FSM RUN: in_ready=1. FSM HALT: in_ready=0, halted=1.
  - RUN->HALT at the edge that pushes (or drops) a mismatch, only when STOP_ON_ERR=1.
  - HALT->RUN only on clear or reset.
- Stage 1: on in_valid&in_ready, all inputs are registered and s1_valid=1 next cycle. sample_cnt increments at the same edge.
- Stage 2 (cycle after acceptance) computes err_code:
  - [0] w_ref != w_dut
  - [1] zero_ref != zero_dut
  - [2] neg_ref != neg_dut
  - [3] reference inconsistent: zero_ref != (w_ref==0), or neg_ref != w_ref[WIDTH-1]
- If s1_valid and err_code != 0 at an edge:
  - mismatch_cnt increments.
  - Record is pushed if FIFO not full, or if full with a simultaneous pop. Otherwise drop_cnt increments.
- Latency: accept at edge N -> compare during cycle N..N+1 -> record visible on err_* with err_valid=1 after edge N+2 (if FIFO was empty). No bypass.
- FIFO:
  - First-word-fall-through registered head; pop on err_valid&err_ready.
  - Pop on empty is ignored.
  - Push and pop together when full keeps occupancy at DEPTH, with no drop.
  - Pointers wrap modulo DEPTH.
  - err_* hold value while err_valid=1 and err_ready=0.
- Counters saturate at 2^CNT_W-1; no wrap.
- clear concurrent with in_valid: transaction discarded and not counted. A stage-1 entry pending at clear is discarded and not counted as mismatch.
- Back-to-back acceptance every cycle is required in RUN (full throughput).

Test Plan:
- Matching stream: 10 transactions with w_ref=w_dut, flags consistent (e.g. a=16'h0003, b=16'h0005, w=16'h0008, z=0, n=0) -> sample_cnt=10, mismatch_cnt=0, err_valid never 1.
- Single result mismatch: w_ref=16'h1234, w_dut=16'h1235, z=0, n=0 accepted at edge N -> err_valid=1 after edge N+2, err_code=4'b0001, err_w_dut=16'h1235, mismatch_cnt=1.
- Inconsistent reference flags: w_ref=w_dut=16'h8000, zero_ref=zero_dut=1, neg_ref=neg_dut=1 -> err_code=4'b1000.
- FIFO overflow: err_ready=0, 6 consecutive mismatches with DEPTH=4 -> FIFO holds first 4 in order, drop_cnt=2, mismatch_cnt=6. Then err_ready=1 for 4 cycles -> 4 records popped in order, err_valid=0.
- Full with simultaneous pop: FIFO full, err_ready=1 as a mismatch arrives -> drop_cnt unchanged, occupancy stays 4.
- STOP_ON_ERR=1: mismatch on 3rd of 5 back-to-back transactions -> halted=1 and in_ready=0 after its compare edge; 4th was already accepted and is compared (sample_cnt=4). Pulse clear -> counters 0, err_valid=0, in_ready=1, halted=0.
- rst_n=0 for one cycle mid-stream with FIFO holding 2 records -> all outputs at reset values next cycle.

Source files
------------

// File: rtl/alu_result_checker.sv
// Lockstep checker for a reference/DUT ALU pair: registers each transaction, compares the
// results and flags a cycle later, counts samples and mismatches, and queues mismatch records.
module alu_result_checker #(
    parameter int unsigned WIDTH       = 16,
    parameter int unsigned OPW         = 3,
    parameter int unsigned DEPTH       = 4,
    parameter int unsigned CNT_W       = 16,
    parameter bit          STOP_ON_ERR = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c,
    input  logic [OPW-1:0]   opcode,
    input  logic [WIDTH-1:0] w_ref,
    input  logic             zero_ref,
    input  logic             neg_ref,
    input  logic [WIDTH-1:0] w_dut,
    input  logic             zero_dut,
    input  logic             neg_dut,
    output logic             err_valid,
    input  logic             err_ready,
    output logic [WIDTH-1:0] err_a,
    output logic [WIDTH-1:0] err_b,
    output logic             err_c,
    output logic [OPW-1:0]   err_opcode,
    output logic [WIDTH-1:0] err_w_ref,
    output logic [WIDTH-1:0] err_w_dut,
    output logic [3:0]       err_code,
    output logic [CNT_W-1:0] sample_cnt,
    output logic [CNT_W-1:0] mismatch_cnt,
    output logic [CNT_W-1:0] drop_cnt,
    output logic             halted
);

    localparam int unsigned AW       = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    typedef enum logic {StRun, StHalt} state_e;

    typedef struct packed {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic             c;
        logic [OPW-1:0]   opcode;
        logic [WIDTH-1:0] w_ref;
        logic             zero_ref;
        logic             neg_ref;
        logic [WIDTH-1:0] w_dut;
        logic             zero_dut;
        logic             neg_dut;
    } txn_t;

    typedef struct packed {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic             c;
        logic [OPW-1:0]   opcode;
        logic [WIDTH-1:0] w_ref;
        logic [WIDTH-1:0] w_dut;
        logic [3:0]       code;
    } rec_t;

    state_e           state_q;
    logic             s1_valid_q;
    txn_t             s1_q;
    txn_t             in_txn;
    rec_t             new_rec;
    logic [3:0]       code_s2;
    logic             accept, mismatch, full, pop, push, drop;
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, remain;
    rec_t             mem_q [DEPTH];
    rec_t             head_q;
    logic             head_valid_q;
    logic [CNT_W-1:0] sample_q, mismatch_q, drop_q;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    assign in_ready = (state_q == StRun);
    assign halted   = (state_q == StHalt);

    always_comb begin
        in_txn.a        = a;
        in_txn.b        = b;
        in_txn.c        = c;
        in_txn.opcode   = opcode;
        in_txn.w_ref    = w_ref;
        in_txn.zero_ref = zero_ref;
        in_txn.neg_ref  = neg_ref;
        in_txn.w_dut    = w_dut;
        in_txn.zero_dut = zero_dut;
        in_txn.neg_dut  = neg_dut;

        code_s2[0] = s1_q.w_ref != s1_q.w_dut;
        code_s2[1] = s1_q.zero_ref != s1_q.zero_dut;
        code_s2[2] = s1_q.neg_ref != s1_q.neg_dut;
        code_s2[3] = (s1_q.zero_ref != (s1_q.w_ref == '0)) ||
                     (s1_q.neg_ref != s1_q.w_ref[WIDTH-1]);

        new_rec.a      = s1_q.a;
        new_rec.b      = s1_q.b;
        new_rec.c      = s1_q.c;
        new_rec.opcode = s1_q.opcode;
        new_rec.w_ref  = s1_q.w_ref;
        new_rec.w_dut  = s1_q.w_dut;
        new_rec.code   = code_s2;

        accept   = in_valid && in_ready;
        mismatch = s1_valid_q && (code_s2 != 4'b0000);
        full     = (count_q == FULL_CNT);
        pop      = head_valid_q && err_ready;
        push     = mismatch && (!full || pop);
        drop     = mismatch && !push;
        rd_ptr_d = rd_ptr_q + AW'(pop);
        // Entries pushed at this edge are excluded, so a fresh record shows one edge later.
        remain   = count_q - (AW + 1)'(pop);
    end

    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            state_q      <= StRun;
            s1_valid_q   <= 1'b0;
            s1_q         <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            head_q       <= '0;
            head_valid_q <= 1'b0;
            sample_q     <= '0;
            mismatch_q   <= '0;
            drop_q       <= '0;
        end else begin
            if (STOP_ON_ERR && mismatch) state_q <= StHalt;
            s1_valid_q <= accept;
            if (accept) begin
                s1_q     <= in_txn;
                sample_q <= sat_inc(sample_q);
            end
            if (mismatch) mismatch_q <= sat_inc(mismatch_q);
            if (drop) drop_q <= sat_inc(drop_q);
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= remain + (AW + 1)'(push);
            head_valid_q <= (remain != '0);
            if (remain != '0) head_q <= mem_q[rd_ptr_d];
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n && !clear && push) mem_q[wr_ptr_q] <= new_rec;
    end

    assign err_valid    = head_valid_q;
    assign err_a        = head_q.a;
    assign err_b        = head_q.b;
    assign err_c        = head_q.c;
    assign err_opcode   = head_q.opcode;
    assign err_w_ref    = head_q.w_ref;
    assign err_w_dut    = head_q.w_dut;
    assign err_code     = head_q.code;
    assign sample_cnt   = sample_q;
    assign mismatch_cnt = mismatch_q;
    assign drop_cnt     = drop_q;

endmodule

// File: tb/tb_alu_result_checker.sv
// Randomized and directed bench for alu_result_checker: a queue-based reference model feeds a
// scoreboard that a negedge monitor drains whenever the checker pops a mismatch record.
module tb_alu_result_checker;

    localparam int W     = 16;
    localparam int OPW   = 3;
    localparam int DEPTH = 4;
    localparam int CW    = 16;

    typedef struct {
        logic [W-1:0]   a, b;
        logic           c;
        logic [OPW-1:0] op;
        logic [W-1:0]   w_ref;
        logic           zr, nr;
        logic [W-1:0]   w_dut;
        logic           zd, nd;
    } txn_t;

    typedef struct {
        logic [W-1:0]   a, b;
        logic           c;
        logic [OPW-1:0] op;
        logic [W-1:0]   w_ref, w_dut;
        logic [3:0]     code;
        int             vis;
    } rec_t;

    logic clk = 1'b0, rst_n = 1'b0, clear = 1'b0, in_valid = 1'b0, err_ready = 1'b0;
    logic [W-1:0] a = '0, b = '0, w_ref = '0, w_dut = '0;
    logic c = 1'b0, zero_ref = 1'b0, neg_ref = 1'b0, zero_dut = 1'b0, neg_dut = 1'b0;
    logic [OPW-1:0] opcode = '0;

    logic in_ready, err_valid, err_c, halted;
    logic [W-1:0] err_a, err_b, err_w_ref, err_w_dut;
    logic [OPW-1:0] err_opcode;
    logic [3:0] err_code;
    logic [CW-1:0] sample_cnt, mismatch_cnt, drop_cnt;

    logic h_in_ready, h_err_valid, h_err_c, h_halted;
    logic [W-1:0] h_err_a, h_err_b, h_err_w_ref, h_err_w_dut;
    logic [OPW-1:0] h_err_opcode;
    logic [3:0] h_err_code;
    logic [CW-1:0] h_sample_cnt, h_mismatch_cnt, h_drop_cnt;

    alu_result_checker #(.WIDTH(W), .OPW(OPW), .DEPTH(DEPTH), .CNT_W(CW), .STOP_ON_ERR(1'b0)) dut (
        .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .c(c), .opcode(opcode), .w_ref(w_ref), .zero_ref(zero_ref),
        .neg_ref(neg_ref), .w_dut(w_dut), .zero_dut(zero_dut), .neg_dut(neg_dut),
        .err_valid(err_valid), .err_ready(err_ready), .err_a(err_a), .err_b(err_b),
        .err_c(err_c), .err_opcode(err_opcode), .err_w_ref(err_w_ref), .err_w_dut(err_w_dut),
        .err_code(err_code), .sample_cnt(sample_cnt), .mismatch_cnt(mismatch_cnt),
        .drop_cnt(drop_cnt), .halted(halted)
    );

    alu_result_checker #(.WIDTH(W), .OPW(OPW), .DEPTH(DEPTH), .CNT_W(CW), .STOP_ON_ERR(1'b1)) dut_h (
        .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_ready(h_in_ready),
        .a(a), .b(b), .c(c), .opcode(opcode), .w_ref(w_ref), .zero_ref(zero_ref),
        .neg_ref(neg_ref), .w_dut(w_dut), .zero_dut(zero_dut), .neg_dut(neg_dut),
        .err_valid(h_err_valid), .err_ready(err_ready), .err_a(h_err_a), .err_b(h_err_b),
        .err_c(h_err_c), .err_opcode(h_err_opcode), .err_w_ref(h_err_w_ref),
        .err_w_dut(h_err_w_dut), .err_code(h_err_code), .sample_cnt(h_sample_cnt),
        .mismatch_cnt(h_mismatch_cnt), .drop_cnt(h_drop_cnt), .halted(h_halted)
    );

    initial forever #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model state, updated once per rising edge.
    bit   mon_en = 1'b0;
    int   m_cyc = 0;
    bit   m_pend_v = 1'b0;
    txn_t m_pend;
    rec_t m_fifo[$];
    rec_t exp_q[$];
    int   m_sample = 0, m_mism = 0, m_drop = 0;

    function automatic logic [3:0] spec_code(input txn_t t);
        logic [3:0] r;
        r[0] = t.w_ref != t.w_dut;
        r[1] = t.zr != t.zd;
        r[2] = t.nr != t.nd;
        r[3] = (t.zr != (t.w_ref == 0)) || (t.nr != t.w_ref[W-1]);
        return r;
    endfunction

    function automatic int sat(input int v);
        return (v >= (1 << CW) - 1) ? v : v + 1;
    endfunction

    function automatic txn_t cur_txn();
        txn_t t;
        t.a = a; t.b = b; t.c = c; t.op = opcode;
        t.w_ref = w_ref; t.zr = zero_ref; t.nr = neg_ref;
        t.w_dut = w_dut; t.zd = zero_dut; t.nd = neg_dut;
        return t;
    endfunction

    function automatic txn_t good_txn(input logic [W-1:0] x, input logic [W-1:0] y,
                                      input logic ci, input logic [OPW-1:0] op);
        txn_t t;
        logic [W-1:0] w;
        case (op)
            3'd0:    w = x + y + W'(ci);
            3'd1:    w = x - y - W'(ci);
            3'd2:    w = x & y;
            3'd3:    w = x | y;
            3'd4:    w = x ^ y;
            3'd5:    w = x << 1;
            3'd6:    w = x >> 1;
            default: w = y;
        endcase
        t.a = x; t.b = y; t.c = ci; t.op = op;
        t.w_ref = w; t.zr = (w == 0); t.nr = w[W-1];
        t.w_dut = w; t.zd = t.zr; t.nd = t.nr;
        return t;
    endfunction

    function automatic txn_t rand_txn();
        txn_t t;
        t = good_txn(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)),
                     OPW'($urandom_range(0, 7)));
        case ($urandom_range(0, 9))
            1: t.w_dut = t.w_dut ^ (W'(1) << $urandom_range(0, W - 1));
            2: t.zd = ~t.zd;
            3: t.nd = ~t.nd;
            4: begin t.zr = ~t.zr; t.zd = t.zr; end
            5: begin t.nr = ~t.nr; t.nd = t.nr; end
            default: ;
        endcase
        return t;
    endfunction

    initial begin
        rec_t r;
        logic [3:0] code;
        bit pop;
        forever begin
            @(posedge clk);
            m_cyc++;
            if (!rst_n || clear) begin
                m_pend_v = 1'b0;
                m_fifo.delete();
                exp_q.delete();
                m_sample = 0; m_mism = 0; m_drop = 0;
            end else begin
                // A record pushed at edge p is poppable from edge p+2 onward.
                pop = (m_fifo.size() > 0) && (m_fifo[0].vis <= m_cyc) && err_ready;
                if (pop) void'(m_fifo.pop_front());
                if (m_pend_v) begin
                    code = spec_code(m_pend);
                    if (code != 4'b0000) begin
                        m_mism = sat(m_mism);
                        if (m_fifo.size() < DEPTH) begin
                            r.a = m_pend.a; r.b = m_pend.b; r.c = m_pend.c; r.op = m_pend.op;
                            r.w_ref = m_pend.w_ref; r.w_dut = m_pend.w_dut; r.code = code;
                            r.vis = m_cyc + 2;
                            m_fifo.push_back(r);
                            exp_q.push_back(r);
                        end else begin
                            m_drop = sat(m_drop);
                        end
                    end
                end
                m_pend_v = in_valid;
                if (in_valid) begin
                    m_pend   = cur_txn();
                    m_sample = sat(m_sample);
                end
            end
        end
    end

    initial begin
        rec_t r;
        bit exp_v;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                exp_v = (m_fifo.size() > 0) && (m_fifo[0].vis <= m_cyc + 1);
                check("in_ready", in_ready, 1);
                check("halted", halted, 0);
                check("err_valid", err_valid, exp_v);
                check("sample_cnt", sample_cnt, m_sample);
                check("mismatch_cnt", mismatch_cnt, m_mism);
                check("drop_cnt", drop_cnt, m_drop);
                if (err_valid && err_ready) begin
                    if (exp_q.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL pop_unexpected: got record a=%0h, expected none", err_a);
                    end else begin
                        r = exp_q.pop_front();
                        check("rec_a", err_a, r.a);
                        check("rec_b", err_b, r.b);
                        check("rec_c", err_c, r.c);
                        check("rec_opcode", err_opcode, r.op);
                        check("rec_w_ref", err_w_ref, r.w_ref);
                        check("rec_w_dut", err_w_dut, r.w_dut);
                        check("rec_code", err_code, r.code);
                    end
                end
            end
        end
    end

    task automatic step(input txn_t t, input bit v, input bit rdy, input bit clr);
        a = t.a; b = t.b; c = t.c; opcode = t.op;
        w_ref = t.w_ref; zero_ref = t.zr; neg_ref = t.nr;
        w_dut = t.w_dut; zero_dut = t.zd; neg_dut = t.nd;
        in_valid = v; err_ready = rdy; clear = clr;
        @(posedge clk);
        #1;
    endtask

    initial begin
        txn_t t, idle;
        idle = good_txn(0, 0, 0, 0);
        rst_n = 1'b0;
        step(idle, 0, 0, 0);
        mon_en = 1'b1;
        step(idle, 0, 0, 0);
        check("reset_in_ready", in_ready, 1);
        check("reset_err_valid", err_valid, 0);
        rst_n = 1'b1;

        // Matching stream
        for (int i = 0; i < 10; i++) step(good_txn(16'h0003, 16'h0005, 0, 0), 1, 1, 0);
        for (int i = 0; i < 3; i++) step(idle, 0, 1, 0);
        check("match_sample_cnt", sample_cnt, 10);
        check("match_mismatch_cnt", mismatch_cnt, 0);

        // Single result mismatch: latency of two edges to err_valid
        t = good_txn(16'h1233, 16'h0001, 0, 0);
        t.w_dut = 16'h1235;
        step(t, 1, 0, 0);
        check("lat_n0_valid", err_valid, 0);
        step(idle, 0, 0, 0);
        check("lat_n1_valid", err_valid, 0);
        step(idle, 0, 0, 0);
        check("lat_n2_valid", err_valid, 1);
        check("single_code", err_code, 4'b0001);
        check("single_w_dut", err_w_dut, 16'h1235);
        check("single_mismatch_cnt", mismatch_cnt, 1);
        step(idle, 0, 1, 0);
        step(idle, 0, 0, 0);

        // Inconsistent reference flags, matching DUT
        t = good_txn(16'h8000, 16'h0000, 0, 0);
        t.zr = 1'b1; t.zd = 1'b1;
        step(t, 1, 0, 0);
        step(idle, 0, 0, 0);
        step(idle, 0, 0, 0);
        check("incons_code", err_code, 4'b1000);
        step(idle, 0, 1, 0);
        step(idle, 0, 0, 0);

        // Overflow: six mismatches into a four-entry FIFO
        step(idle, 0, 0, 1);
        check("clear_sample_cnt", sample_cnt, 0);
        for (int i = 0; i < 6; i++) begin
            t = good_txn(W'(i + 1), 16'h0010, 0, 0);
            t.w_dut = t.w_dut ^ 16'h0100;
            step(t, 1, 0, 0);
        end
        for (int i = 0; i < 3; i++) step(idle, 0, 0, 0);
        check("ovf_drop_cnt", drop_cnt, 2);
        check("ovf_mismatch_cnt", mismatch_cnt, 6);
        check("ovf_head_a", err_a, 1);
        for (int i = 0; i < 4; i++) step(idle, 0, 1, 0);
        check("ovf_drained", err_valid, 0);

        // Full FIFO with a pop coinciding with a new mismatch
        for (int i = 0; i < 5; i++) begin
            t = good_txn(W'(16'h21 + i), 16'h0002, 0, 0);
            t.zd = ~t.zd;
            step(t, 1, 0, 0);
            if (i == 3) for (int k = 0; k < 3; k++) step(idle, 0, 0, 0);
        end
        step(idle, 0, 1, 0);
        step(idle, 0, 0, 0);
        check("fullpop_drop_cnt", drop_cnt, 2);
        check("fullpop_head_a", err_a, 16'h22);
        for (int i = 0; i < 5; i++) step(idle, 0, 1, 0);
        check("fullpop_drained", err_valid, 0);

        // Random traffic with occasional clear
        for (int i = 0; i < 400; i++) begin
            step(rand_txn(), $urandom_range(0, 9) < 8, $urandom_range(0, 9) < 5,
                 $urandom_range(0, 99) == 0);
        end
        for (int i = 0; i < 8; i++) step(idle, 0, 1, 0);

        // Halt on first error (STOP_ON_ERR instance)
        step(idle, 0, 0, 1);
        for (int i = 0; i < 5; i++) begin
            t = good_txn(W'(i), 16'h0001, 0, 0);
            if (i == 2) t.w_dut = t.w_dut ^ 16'h0001;
            step(t, 1, 1, 0);
            if (i == 3) check("halt_in_ready_e4", h_in_ready, 0);
        end
        in_valid = 1'b0;
        check("halt_halted", h_halted, 1);
        check("halt_in_ready", h_in_ready, 0);
        check("halt_sample_cnt", h_sample_cnt, 4);
        check("halt_mismatch_cnt", h_mismatch_cnt, 1);
        step(idle, 0, 0, 0);
        check("halt_err_valid", h_err_valid, 1);
        step(idle, 0, 0, 1);
        check("hclr_sample_cnt", h_sample_cnt, 0);
        check("hclr_mismatch_cnt", h_mismatch_cnt, 0);
        check("hclr_err_valid", h_err_valid, 0);
        check("hclr_in_ready", h_in_ready, 1);
        check("hclr_halted", h_halted, 0);

        // Reset mid-stream with two records queued
        for (int i = 0; i < 2; i++) begin
            t = good_txn(W'(16'h40 + i), 16'h0003, 0, 0);
            t.nd = ~t.nd;
            step(t, 1, 0, 0);
        end
        for (int i = 0; i < 3; i++) step(idle, 0, 0, 0);
        check("rst_pre_valid", err_valid, 1);
        rst_n = 1'b0;
        step(idle, 0, 0, 0);
        rst_n = 1'b1;
        check("rst_err_valid", err_valid, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_err_a", err_a, 0);
        check("rst_err_w_dut", err_w_dut, 0);
        check("rst_err_code", err_code, 0);
        check("rst_sample_cnt", sample_cnt, 0);
        check("rst_mismatch_cnt", mismatch_cnt, 0);
        check("rst_drop_cnt", drop_cnt, 0);
        step(idle, 0, 0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
